// File: rtl/memtest_pkg.sv
// Shared definitions for the memory test sequencer and the LFSR memory checker:
// bus widths, FSM state encoding, test_mode codes and LFSR tap positions.
package memtest_pkg;

    localparam int unsigned SEED_W = 128;
    localparam int unsigned SIZE_W = 32;
    localparam int unsigned DQ_W   = 32;
    localparam int unsigned MODE_W = 2;

    // XNOR feedback taps, common to the checker's pattern generator
    localparam int unsigned TAP_A = 127;
    localparam int unsigned TAP_B = 125;
    localparam int unsigned TAP_C = 100;
    localparam int unsigned TAP_D = 98;

    localparam logic [MODE_W-1:0] MODE_WR_RD = 2'd0;
    localparam logic [MODE_W-1:0] MODE_WR    = 2'd1;
    localparam logic [MODE_W-1:0] MODE_RD    = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_RUN     = 3'd2,
        ST_CHECK   = 3'd3,
        ST_RELEASE = 3'd4,
        ST_NEXT    = 3'd5
    } seq_state_t;

endpackage

// File: rtl/memory_test_sequencer_if.sv
// Sequencer <-> LFSR memory checker control link; master is the sequencer side.
interface memory_test_sequencer_if;
    import memtest_pkg::*;

    logic              chk_start;
    logic [MODE_W-1:0] chk_test_mode;
    logic [SIZE_W-1:0] chk_test_size;
    logic [SEED_W-1:0] chk_seed;
    logic              chk_done;
    logic              chk_fail;
    logic [DQ_W-1:0]   chk_dq_fail;

    modport master (
        output chk_start, chk_test_mode, chk_test_size, chk_seed,
        input  chk_done, chk_fail, chk_dq_fail
    );

    modport slave (
        input  chk_start, chk_test_mode, chk_test_size, chk_seed,
        output chk_done, chk_fail, chk_dq_fail
    );

endinterface

// File: rtl/memtest_lfsr_step.sv
// Combinational single step of the 128-bit XNOR LFSR used for checker seeds.
module memtest_lfsr_step
    import memtest_pkg::*;
(
    input  logic [SEED_W-1:0] seed,
    output logic [SEED_W-1:0] next_seed_c
);

    always_comb begin
        next_seed_c = {seed[SEED_W-2:0],
                       ~(seed[TAP_A] ^ seed[TAP_B] ^ seed[TAP_C] ^ seed[TAP_D])};
    end

endmodule

// File: rtl/memory_test_sequencer.sv
// Runs a programmable number of LFSR memory checker passes and gathers statistics.
// Optional per-pass watchdog: define MEMORY_TEST_SEQUENCER_TIMEOUT_EN.
module memory_test_sequencer
    import memtest_pkg::*;
#(
    parameter int unsigned LOOP_W         = 16,
    parameter int unsigned CYC_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 32'h0800_0000
) (
    input  logic                     axi_clk,
    input  logic                     rst,
    input  logic                     cmd_start,
    input  logic                     cmd_stop,
    input  logic [LOOP_W-1:0]        cfg_loops,
    input  logic [MODE_W-1:0]        cfg_test_mode,
    input  logic [SIZE_W-1:0]        cfg_test_size,
    input  logic [SEED_W-1:0]        cfg_seed,
    input  logic                     cfg_seed_adv,
    memory_test_sequencer_if.master  chk,
    output logic                     busy,
    output logic [LOOP_W-1:0]        loops_done,
    output logic [LOOP_W-1:0]        fail_count,
    output logic [LOOP_W-1:0]        first_fail_loop,
    output logic [DQ_W-1:0]          dq_fail_accum,
    output logic [CYC_W-1:0]         last_cycles,
    output logic                     sticky_fail,
    output logic                     timeout
);

    seq_state_t        state;
    logic [LOOP_W-1:0] loops_lim;
    logic              seed_adv;
    logic              stop_req;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [SEED_W-1:0] next_seed_c;
    logic              wdog_hit_c;
    logic              fin_c;
    logic              fin_fail_c;

    memtest_lfsr_step u_lfsr_step (
        .seed        (chk.chk_seed),
        .next_seed_c (next_seed_c)
    );

`ifdef MEMORY_TEST_SEQUENCER_TIMEOUT_EN
    assign wdog_hit_c = (state == ST_RUN) && !chk.chk_done &&
                        (cyc_cnt >= CYC_W'(TIMEOUT_CYCLES));
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign wdog_hit_c = 1'b0;
`endif

    // A pass finishes either normally in CHECK or by the watchdog (always a failure)
    always_comb begin
        fin_c      = (state == ST_CHECK) || wdog_hit_c;
        fin_fail_c = chk.chk_fail || wdog_hit_c;
    end

    always_ff @(posedge axi_clk or posedge rst) begin
        if (rst) begin
            state             <= ST_IDLE;
            loops_lim         <= '0;
            seed_adv          <= 1'b0;
            stop_req          <= 1'b0;
            cyc_cnt           <= '0;
            chk.chk_start     <= 1'b0;
            chk.chk_test_mode <= '0;
            chk.chk_test_size <= '0;
            chk.chk_seed      <= '0;
            busy              <= 1'b0;
            loops_done        <= '0;
            fail_count        <= '0;
            first_fail_loop   <= '1;
            dq_fail_accum     <= '0;
            last_cycles       <= '0;
            sticky_fail       <= 1'b0;
            timeout           <= 1'b0;
        end else begin
            if (state != ST_IDLE && cmd_stop) begin
                stop_req <= 1'b1;
            end

            if (fin_c) begin
                last_cycles   <= cyc_cnt;
                dq_fail_accum <= dq_fail_accum | chk.chk_dq_fail;
                if (fin_fail_c) begin
                    sticky_fail <= 1'b1;
                    if (fail_count != '1) fail_count <= fail_count + LOOP_W'(1);
                    if (first_fail_loop == '1) first_fail_loop <= loops_done;
                end
                if (loops_done != '1) loops_done <= loops_done + LOOP_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    stop_req <= 1'b0;
                    if (cmd_start) begin
                        loops_lim         <= cfg_loops;
                        seed_adv          <= cfg_seed_adv;
                        chk.chk_test_mode <= cfg_test_mode;
                        chk.chk_test_size <= cfg_test_size;
                        chk.chk_seed      <= cfg_seed;
                        busy              <= 1'b1;
                        loops_done        <= '0;
                        fail_count        <= '0;
                        first_fail_loop   <= '1;
                        dq_fail_accum     <= '0;
                        last_cycles       <= '0;
                        sticky_fail       <= 1'b0;
                        timeout           <= 1'b0;
                        state             <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    chk.chk_start <= 1'b1;
                    cyc_cnt       <= '0;
                    state         <= ST_RUN;
                end
                ST_RUN: begin
                    if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + CYC_W'(1);
                    if (chk.chk_done) begin
                        state <= ST_CHECK;
                    end else if (wdog_hit_c) begin
                        // Abandon the pass and force the sequence to end after release
                        chk.chk_start <= 1'b0;
                        timeout       <= 1'b1;
                        stop_req      <= 1'b1;
                        state         <= ST_RELEASE;
                    end
                end
                ST_CHECK: begin
                    chk.chk_start <= 1'b0;
                    state         <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!chk.chk_done) state <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (stop_req || (loops_lim != '0 && loops_done == loops_lim)) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        if (seed_adv) chk.chk_seed <= next_seed_c;
                        state <= ST_LAUNCH;
                    end
                end
                default: begin
                    chk.chk_start <= 1'b0;
                    busy          <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_test_sequencer.sv
// Self-checking bench: behavioural checker model plus a seed scoreboard per pass.
module tb_memory_test_sequencer;
    import memtest_pkg::*;

    logic          axi_clk;
    logic          rst;
    logic          cmd_start;
    logic          cmd_stop;
    logic [15:0]   cfg_loops;
    logic [1:0]    cfg_test_mode;
    logic [31:0]   cfg_test_size;
    logic [127:0]  cfg_seed;
    logic          cfg_seed_adv;
    logic          busy;
    logic [15:0]   loops_done;
    logic [15:0]   fail_count;
    logic [15:0]   first_fail_loop;
    logic [31:0]   dq_fail_accum;
    logic [31:0]   last_cycles;
    logic          sticky_fail;
    logic          timeout;

    memory_test_sequencer_if chk_if ();

    memory_test_sequencer #(
        .LOOP_W (16),
        .CYC_W  (32)
`ifdef MEMORY_TEST_SEQUENCER_TIMEOUT_EN
        , .TIMEOUT_CYCLES (50)
`endif
    ) dut (
        .axi_clk         (axi_clk),
        .rst             (rst),
        .cmd_start       (cmd_start),
        .cmd_stop        (cmd_stop),
        .cfg_loops       (cfg_loops),
        .cfg_test_mode   (cfg_test_mode),
        .cfg_test_size   (cfg_test_size),
        .cfg_seed        (cfg_seed),
        .cfg_seed_adv    (cfg_seed_adv),
        .chk             (chk_if.master),
        .busy            (busy),
        .loops_done      (loops_done),
        .fail_count      (fail_count),
        .first_fail_loop (first_fail_loop),
        .dq_fail_accum   (dq_fail_accum),
        .last_cycles     (last_cycles),
        .sticky_fail     (sticky_fail),
        .timeout         (timeout)
    );

    int errors = 0;
    int checks = 0;

    // checker model knobs
    int          m_delay    = 100;
    bit          m_hang     = 1'b0;
    int          m_fail_idx = -1;
    logic [31:0] m_fail_dq  = '0;
    int          m_cnt;
    int          m_pass;

    logic        start_d;
    int          low_len;
    logic [127:0] seed_q[$];

    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    function automatic logic [127:0] lfsr_next(input logic [127:0] s);
        return {s[126:0], ~(s[127] ^ s[125] ^ s[100] ^ s[98])};
    endfunction

    // Checker model: done 'm_delay' cycles after start rises, held until start drops
    always @(posedge axi_clk or posedge rst) begin
        if (rst) begin
            m_cnt              <= 0;
            m_pass             <= 0;
            chk_if.chk_done    <= 1'b0;
            chk_if.chk_fail    <= 1'b0;
            chk_if.chk_dq_fail <= '0;
        end else begin
            if (!chk_if.chk_start) begin
                if (m_cnt != 0) m_pass <= m_pass + 1;
                m_cnt              <= 0;
                chk_if.chk_done    <= 1'b0;
                chk_if.chk_fail    <= 1'b0;
                chk_if.chk_dq_fail <= '0;
            end else begin
                m_cnt <= m_cnt + 1;
                if (!m_hang && (m_cnt + 1 >= m_delay - 1)) begin
                    chk_if.chk_done    <= 1'b1;
                    chk_if.chk_fail    <= (m_pass == m_fail_idx);
                    chk_if.chk_dq_fail <= (m_pass == m_fail_idx) ? m_fail_dq : 32'h0;
                end
            end
            if (cmd_start) m_pass <= 0;
        end
    end

    always @(posedge axi_clk) begin
        start_d <= chk_if.chk_start;
        low_len <= chk_if.chk_start ? 0 : low_len + 1;
    end

    task automatic start_seq(input logic [15:0] loops, input logic [1:0] mode,
                             input logic [31:0] size, input logic [127:0] seed,
                             input logic adv, input logic with_stop);
        @(negedge axi_clk);
        cfg_loops     = loops;
        cfg_test_mode = mode;
        cfg_test_size = size;
        cfg_seed      = seed;
        cfg_seed_adv  = adv;
        cmd_start     = 1'b1;
        cmd_stop      = with_stop;
        @(negedge axi_clk);
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
    endtask

    task automatic wait_start_rise(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge axi_clk);
            if (chk_if.chk_start && !start_d) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge axi_clk);
            if (!busy) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({busy, loops_done, fail_count, sticky_fail, timeout, chk_if.chk_start} !== '0) begin
            errors++;
            $display("FAIL reset_zero: busy=%b loops=%0d fails=%0d sticky=%b to=%b start=%b required all 0",
                     busy, loops_done, fail_count, sticky_fail, timeout, chk_if.chk_start);
        end
        checks++;
        if (first_fail_loop !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_first_fail: got %h required ffff", first_fail_loop);
        end
        checks++;
        if ({dq_fail_accum, last_cycles} !== 64'h0 || chk_if.chk_seed !== 128'h0) begin
            errors++;
            $display("FAIL reset_regs: dq=%h cyc=%0d seed=%h required 0", dq_fail_accum, last_cycles, chk_if.chk_seed);
        end
    endtask

    // Per-pass seed scoreboard: pops one expected seed on each chk_start rise
    task automatic run_passes(input int n, input string tag, input logic [1:0] mode, input logic [31:0] size);
        bit ok;
        logic [127:0] exp_seed;
        for (int p = 0; p < n; p++) begin
            wait_start_rise(1000, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s_launch%0d: no chk_start rise within budget", tag, p);
                return;
            end
            checks++;
            if (seed_q.size() == 0) begin
                errors++;
                $display("FAIL %s_extra_pass%0d: unexpected pass, seed=%h", tag, p, chk_if.chk_seed);
            end else begin
                exp_seed = seed_q.pop_front();
                if (chk_if.chk_seed !== exp_seed) begin
                    errors++;
                    $display("FAIL %s_seed%0d: got %h required %h", tag, p, chk_if.chk_seed, exp_seed);
                end
            end
            checks++;
            if (chk_if.chk_test_mode !== mode || chk_if.chk_test_size !== size) begin
                errors++;
                $display("FAIL %s_cfg%0d: mode=%0d size=%h required mode=%0d size=%h",
                         tag, p, chk_if.chk_test_mode, chk_if.chk_test_size, mode, size);
            end
        end
    endtask

    task automatic test_basic;
        bit ok;
        logic [127:0] s;
        m_delay = 100; m_fail_idx = -1;
        seed_q.delete();
        s = 128'h1;
        for (int i = 0; i < 3; i++) begin seed_q.push_back(s); s = lfsr_next(s); end
        start_seq(16'd3, MODE_WR_RD, 32'h0000_1000, 128'h1, 1'b1, 1'b0);
        run_passes(3, "basic", MODE_WR_RD, 32'h0000_1000);
        wait_idle(1000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_idle: busy still %b", busy); end
        checks++;
        if (loops_done !== 16'd3 || fail_count !== 16'd0 || sticky_fail !== 1'b0) begin
            errors++;
            $display("FAIL basic_counts: loops=%0d fails=%0d sticky=%b required 3/0/0", loops_done, fail_count, sticky_fail);
        end
        checks++;
        if (last_cycles !== 32'd100) begin
            errors++;
            $display("FAIL basic_cycles: got %0d required 100", last_cycles);
        end
        checks++;
        if (first_fail_loop !== 16'hFFFF || chk_if.chk_start !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle_state: first=%h start=%b required ffff/0", first_fail_loop, chk_if.chk_start);
        end
    endtask

    task automatic test_fail_accum;
        bit ok;
        m_delay = 20; m_fail_idx = 2; m_fail_dq = 32'h0000_0101;
        seed_q.delete();
        for (int i = 0; i < 4; i++) seed_q.push_back(128'h1);
        start_seq(16'd4, MODE_WR, 32'h0000_0040, 128'h1, 1'b0, 1'b0);
        run_passes(4, "fail", MODE_WR, 32'h0000_0040);
        wait_idle(500, ok);
        checks++;
        if (!ok || loops_done !== 16'd4) begin
            errors++;
            $display("FAIL fail_loops: idle=%b loops=%0d required 1/4", ok, loops_done);
        end
        checks++;
        if (fail_count !== 16'd1 || first_fail_loop !== 16'd2 || sticky_fail !== 1'b1) begin
            errors++;
            $display("FAIL fail_stats: fails=%0d first=%0d sticky=%b required 1/2/1", fail_count, first_fail_loop, sticky_fail);
        end
        checks++;
        if (dq_fail_accum !== 32'h0000_0101 || last_cycles !== 32'd20) begin
            errors++;
            $display("FAIL fail_dq: dq=%h cyc=%0d required 00000101/20", dq_fail_accum, last_cycles);
        end
        m_fail_idx = -1;
    endtask

    task automatic test_stop;
        bit ok;
        logic [127:0] s;
        m_delay = 10;
        seed_q.delete();
        s = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        for (int i = 0; i < 6; i++) begin seed_q.push_back(s); s = lfsr_next(s); end
        start_seq(16'd0, MODE_RD, 32'h0000_0008, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b1, 1'b0);
        run_passes(6, "stop", MODE_RD, 32'h0000_0008);
        cmd_stop = 1'b1;
        @(negedge axi_clk);
        cmd_stop = 1'b0;
        wait_idle(500, ok);
        checks++;
        if (!ok || loops_done !== 16'd6 || fail_count !== 16'd0) begin
            errors++;
            $display("FAIL stop_loops: idle=%b loops=%0d fails=%0d required 1/6/0", ok, loops_done, fail_count);
        end
    endtask

    task automatic test_seed_adv;
        bit ok;
        logic [127:0] ones;
        int gap;
        ones = '1;
        m_delay = 8;
        for (int adv = 1; adv >= 0; adv--) begin
            seed_q.delete();
            seed_q.push_back(ones);
            seed_q.push_back(adv != 0 ? lfsr_next(ones) : ones);
            start_seq(16'd2, MODE_WR_RD, 32'h10, ones, adv[0], 1'b0);
            run_passes(1, "adv_a", MODE_WR_RD, 32'h10);
            run_passes(1, "adv_b", MODE_WR_RD, 32'h10);
            gap = low_len;
            checks++;
            if (gap < 3) begin
                errors++;
                $display("FAIL seed_gap: start low for %0d cycles, required >= 3", gap);
            end
            wait_idle(200, ok);
            checks++;
            if (!ok || loops_done !== 16'd2) begin
                errors++;
                $display("FAIL seed_adv_done: idle=%b loops=%0d required 1/2", ok, loops_done);
            end
        end
    endtask

    task automatic test_busy_start;
        bit ok;
        m_delay = 30;
        seed_q.delete();
        seed_q.push_back(128'h5);
        seed_q.push_back(128'h5);
        start_seq(16'd2, MODE_WR, 32'h20, 128'h5, 1'b0, 1'b0);
        run_passes(1, "busy_a", MODE_WR, 32'h20);
        start_seq(16'd5, MODE_RD, 32'h99, 128'h77, 1'b1, 1'b0);
        run_passes(1, "busy_b", MODE_WR, 32'h20);
        wait_idle(300, ok);
        checks++;
        if (!ok || loops_done !== 16'd2) begin
            errors++;
            $display("FAIL busy_start_ignored: idle=%b loops=%0d required 1/2", ok, loops_done);
        end
        // start and stop together in IDLE: the full sequence must run
        seed_q.delete();
        seed_q.push_back(128'h9);
        seed_q.push_back(128'h9);
        start_seq(16'd2, MODE_WR_RD, 32'h4, 128'h9, 1'b0, 1'b1);
        run_passes(2, "startstop", MODE_WR_RD, 32'h4);
        wait_idle(300, ok);
        checks++;
        if (!ok || loops_done !== 16'd2) begin
            errors++;
            $display("FAIL start_stop_same_cycle: idle=%b loops=%0d required 1/2", ok, loops_done);
        end
    endtask

    task automatic test_reset_mid_run;
        m_delay = 60;
        seed_q.delete();
        seed_q.push_back(128'h3);
        seed_q.push_back(128'h3);
        start_seq(16'd3, MODE_WR, 32'h8, 128'h3, 1'b0, 1'b0);
        run_passes(2, "rstrun", MODE_WR, 32'h8);
        checks++;
        if (loops_done !== 16'd1 || last_cycles !== 32'd60) begin
            errors++;
            $display("FAIL rst_precond: loops=%0d cyc=%0d required 1/60", loops_done, last_cycles);
        end
        repeat (10) @(negedge axi_clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (chk_if.chk_start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_start_drop: start=%b busy=%b required 0/0", chk_if.chk_start, busy);
        end
        checks++;
        if (loops_done !== 16'd0 || last_cycles !== 32'd0 || first_fail_loop !== 16'hFFFF) begin
            errors++;
            $display("FAIL rst_counters: loops=%0d cyc=%0d first=%h required 0/0/ffff",
                     loops_done, last_cycles, first_fail_loop);
        end
        @(negedge axi_clk);
        rst = 1'b0;
        @(negedge axi_clk);
    endtask

    task automatic test_timeout;
        bit ok;
`ifdef MEMORY_TEST_SEQUENCER_TIMEOUT_EN
        m_hang = 1'b1;
        start_seq(16'd3, MODE_WR_RD, 32'h40, 128'h1, 1'b1, 1'b0);
        wait_idle(500, ok);
        m_hang = 1'b0;
        checks++;
        if (!ok || timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_fire: idle=%b timeout=%b required 1/1", ok, timeout);
        end
        checks++;
        if (fail_count !== 16'd1 || loops_done !== 16'd1 || sticky_fail !== 1'b1 || first_fail_loop !== 16'd0) begin
            errors++;
            $display("FAIL timeout_stats: fails=%0d loops=%0d sticky=%b first=%0d required 1/1/1/0",
                     fail_count, loops_done, sticky_fail, first_fail_loop);
        end
`else
        ok = 1'b1;
        checks++;
        if (timeout !== 1'b0 || !ok) begin
            errors++;
            $display("FAIL timeout_tied: got %b required 0", timeout);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        cmd_start = 1'b0;
        cmd_stop = 1'b0;
        cfg_loops = '0;
        cfg_test_mode = MODE_WR_RD;
        cfg_test_size = '0;
        cfg_seed = '0;
        cfg_seed_adv = 1'b0;
        repeat (3) @(negedge axi_clk);
        test_reset();
        rst = 1'b0;
        @(negedge axi_clk);
        test_basic();
        test_fail_accum();
        test_stop();
        test_seed_adv();
        test_busy_start();
        test_reset_mid_run();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
